// File: rtl/uart_reg_bridge_pkg.sv
// uart_reg_bridge shared definitions.
// Command bytes, response defaults and FSM encoding.
package uart_reg_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] ACK_DEF   = 8'h06;
  localparam logic [7:0] NAK_DEF   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_WAIT_RD,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_reg_bridge_timer.sv
// uart_reg_bridge timeout counter.
// Loadable saturating down-counter; expired while count is zero.
module uart_reg_bridge_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  // load wins over clear; otherwise count down and stick at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge top.
// Decodes W/R host commands into register-bus accesses.
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int         DATA_BITS    = 8,
  parameter int         BYTE_TIMEOUT = 1_000_000,
  parameter int         RD_TIMEOUT   = 255,
  parameter logic [7:0] ACK_BYTE     = ACK_DEF,
  parameter logic [7:0] NAK_BYTE     = NAK_DEF
) (
  input  logic                 CLK,
  input  logic                 NRST,
  input  logic [DATA_BITS-1:0] RX_DO,
  input  logic                 RX_DRDY,
  output logic [DATA_BITS-1:0] TX_DI,
  output logic                 TX_DRDY,
  input  logic                 TX_BUSY,
  input  logic                 TX_DONE,
  output logic [7:0]           BUS_ADDR,
  output logic [7:0]           BUS_WDATA,
  output logic                 BUS_WE,
  output logic                 BUS_RE,
  input  logic [7:0]           BUS_RDATA,
  input  logic                 BUS_RVALID,
  output logic                 OVERRUN
);

  localparam int TMAX = max_int(BYTE_TIMEOUT, RD_TIMEOUT);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] BYTE_LD = TW'(BYTE_TIMEOUT - 1);
  localparam logic [TW-1:0] RD_LD   = TW'(RD_TIMEOUT - 1);

  state_t state;
  logic   op_wr;
  logic [7:0] rx_b;
  logic   is_wr_cmd;
  logic   is_rd_cmd;

  logic                 send_req;
  logic [DATA_BITS-1:0] send_val;
  logic                 tmr_clear;
  logic                 tmr_load;
  logic [TW-1:0]        tmr_val;
  logic                 tmr_exp;

  assign rx_b      = 8'(RX_DO);
  assign is_wr_cmd = (rx_b == CMD_WRITE);
  assign is_rd_cmd = (rx_b == CMD_READ);

  assign OVERRUN = RX_DRDY &&
    (state inside {ST_BUS_WR, ST_BUS_RD, ST_WAIT_RD,
                   ST_SEND, ST_WAIT_TX});

  uart_reg_bridge_timer #(
    .W(TW)
  ) u_timer (
    .clk     (CLK),
    .rst_n   (NRST),
    .clear   (tmr_clear),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expired (tmr_exp)
  );

  // response selection and timer reload per state
  always_comb begin
    send_req  = 1'b0;
    send_val  = '0;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    unique case (state)
      ST_IDLE: begin
        tmr_clear = 1'b1;
        if (RX_DRDY) begin
          if (is_wr_cmd || is_rd_cmd) begin
            tmr_load = 1'b1;
            tmr_val  = BYTE_LD;
          end else begin
            send_req = 1'b1;
            send_val = DATA_BITS'(NAK_BYTE);
          end
        end
      end
      ST_GET_ADDR: begin
        if (RX_DRDY) begin
          tmr_load = 1'b1;
          tmr_val  = op_wr ? BYTE_LD : RD_LD;
        end
      end
      ST_BUS_WR: begin
        send_req = 1'b1;
        send_val = DATA_BITS'(ACK_BYTE);
      end
      ST_WAIT_RD: begin
        if (BUS_RVALID) begin
          send_req = 1'b1;
          send_val = DATA_BITS'(BUS_RDATA);
        end else if (tmr_exp) begin
          send_req = 1'b1;
          send_val = DATA_BITS'(NAK_BYTE);
        end
      end
      default: ;
    endcase
  end

  // command FSM with registered bus and tx outputs
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state     <= ST_IDLE;
      op_wr     <= 1'b0;
      BUS_ADDR  <= '0;
      BUS_WDATA <= '0;
      BUS_WE    <= 1'b0;
      BUS_RE    <= 1'b0;
      TX_DI     <= '0;
      TX_DRDY   <= 1'b0;
    end else begin
      BUS_WE  <= 1'b0;
      BUS_RE  <= 1'b0;
      TX_DRDY <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (RX_DRDY) begin
            unique case (1'b1)
              is_wr_cmd: begin
                op_wr <= 1'b1;
                state <= ST_GET_ADDR;
              end
              is_rd_cmd: begin
                op_wr <= 1'b0;
                state <= ST_GET_ADDR;
              end
              default: ;
            endcase
          end
        end
        ST_GET_ADDR: begin
          if (RX_DRDY) begin
            BUS_ADDR <= rx_b;
            if (op_wr) begin
              state <= ST_GET_DATA;
            end else begin
              BUS_RE <= 1'b1;
              state  <= ST_BUS_RD;
            end
          end else if (tmr_exp) begin
            state <= ST_IDLE;
          end
        end
        ST_GET_DATA: begin
          if (RX_DRDY) begin
            BUS_WDATA <= rx_b;
            BUS_WE    <= 1'b1;
            state     <= ST_BUS_WR;
          end else if (tmr_exp) begin
            state <= ST_IDLE;
          end
        end
        ST_BUS_RD: state <= ST_WAIT_RD;
        ST_SEND: begin
          if (!TX_BUSY) begin
            TX_DRDY <= 1'b1;
            state   <= ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          if (TX_DONE) state <= ST_IDLE;
        end
        default: ;
      endcase
      if (send_req) begin
        TX_DI <= send_val;
        if (!TX_BUSY) begin
          TX_DRDY <= 1'b1;
          state   <= ST_WAIT_TX;
        end else begin
          state <= ST_SEND;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// uart_reg_bridge testbench.
// Scoreboard of timed expected events checked by a monitor.
module tb_uart_reg_bridge;

  localparam int EV_WE  = 0;
  localparam int EV_RE  = 1;
  localparam int EV_TX  = 2;
  localparam int EV_OVR = 3;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
  } ev_t;

  logic       CLK;
  logic       NRST;
  logic [7:0] RX_DO;
  logic       RX_DRDY;
  logic [7:0] TX_DI;
  logic       TX_DRDY;
  logic       TX_BUSY;
  logic       TX_DONE;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_WDATA;
  logic       BUS_WE;
  logic       BUS_RE;
  logic [7:0] BUS_RDATA;
  logic       BUS_RVALID;
  logic       OVERRUN;

  logic force_busy;
  logic model_busy;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   rd_delay;
  logic [7:0] rd_data;
  ev_t  sb[$];

  assign TX_BUSY = force_busy | model_busy;

  uart_reg_bridge #(
    .DATA_BITS   (8),
    .BYTE_TIMEOUT(50),
    .RD_TIMEOUT  (16),
    .ACK_BYTE    (8'h06),
    .NAK_BYTE    (8'h15)
  ) dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .RX_DO     (RX_DO),
    .RX_DRDY   (RX_DRDY),
    .TX_DI     (TX_DI),
    .TX_DRDY   (TX_DRDY),
    .TX_BUSY   (TX_BUSY),
    .TX_DONE   (TX_DONE),
    .BUS_ADDR  (BUS_ADDR),
    .BUS_WDATA (BUS_WDATA),
    .BUS_WE    (BUS_WE),
    .BUS_RE    (BUS_RE),
    .BUS_RDATA (BUS_RDATA),
    .BUS_RVALID(BUS_RVALID),
    .OVERRUN   (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic expect_ev(input string nm, input int kind,
                           input logic [7:0] a, input logic [7:0] b,
                           input int c);
    ev_t e;
    e.name = nm;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic chk(input int kind, input logic [7:0] a,
                     input logic [7:0] b);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected: kind=%0d a=%h b=%h cyc=%0d, none required",
               kind, a, b, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.a !== a || e.b !== b || e.cyc != cyc) begin
        n_errors++;
        $display("FAIL %s: got kind=%0d a=%h b=%h cyc=%0d, required kind=%0d a=%h b=%h cyc=%0d",
                 e.name, kind, a, b, cyc, e.kind, e.a, e.b, e.cyc);
      end
    end
  endtask

  task automatic chk_reset(input string nm);
    logic [34:0] v;
    v = {TX_DI, TX_DRDY, BUS_ADDR, BUS_WDATA, BUS_WE, BUS_RE, OVERRUN,
         7'd0};
    n_checks++;
    if (v !== '0) begin
      n_errors++;
      $display("FAIL %s: outputs=%h required 0", nm, v);
    end
  endtask

  // monitor: every DUT output event must match the scoreboard head
  always @(negedge CLK) begin
    if (NRST) begin
      if (BUS_WE)  chk(EV_WE, BUS_ADDR, BUS_WDATA);
      if (BUS_RE)  chk(EV_RE, BUS_ADDR, 8'h00);
      if (TX_DRDY) chk(EV_TX, TX_DI, 8'h00);
      if (OVERRUN) chk(EV_OVR, 8'h00, 8'h00);
    end
  end

  // register-bus responder
  initial begin
    BUS_RVALID = 1'b0;
    BUS_RDATA  = 8'h00;
    forever begin
      @(negedge CLK);
      if (NRST && BUS_RE && rd_delay > 0) begin
        repeat (rd_delay) @(posedge CLK);
        #1;
        BUS_RVALID = 1'b1;
        BUS_RDATA  = rd_data;
        @(posedge CLK);
        #1;
        BUS_RVALID = 1'b0;
        BUS_RDATA  = 8'h00;
      end
    end
  end

  // transmitter model; TX_DI must hold until TX_DONE
  initial begin
    logic [7:0] cap;
    model_busy = 1'b0;
    TX_DONE    = 1'b0;
    forever begin
      @(negedge CLK);
      if (NRST && TX_DRDY) begin
        cap = TX_DI;
        @(posedge CLK);
        #1 model_busy = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        TX_DONE    = 1'b1;
        model_busy = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (TX_DI !== cap) begin
          n_errors++;
          $display("FAIL tx_di_hold: got %h required %h", TX_DI, cap);
        end
        @(posedge CLK);
        #1 TX_DONE = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int n);
    @(posedge CLK);
    #1;
    RX_DO   = b;
    RX_DRDY = 1'b1;
    n       = cyc;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1 RX_DRDY = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cyc        = 0;
    n_checks   = 0;
    n_errors   = 0;
    rd_delay   = -1;
    rd_data    = 8'h00;
    force_busy = 1'b0;
    NRST       = 1'b0;
    RX_DO      = 8'h00;
    RX_DRDY    = 1'b0;
    repeat (3) @(posedge CLK);
    #1 chk_reset("reset_state");
    NRST = 1'b1;
    idle(3);

    // write with long gaps
    send_byte(8'h57, n); idle(40);
    send_byte(8'h10, n); idle(40);
    send_byte(8'hA5, n);
    expect_ev("wr_we", EV_WE, 8'h10, 8'hA5, n + 1);
    expect_ev("wr_ack", EV_TX, 8'h06, 8'h00, n + 2);
    idle(40);

    // read with RVALID three cycles after BUS_RE
    rd_delay = 3;
    rd_data  = 8'h3C;
    send_byte(8'h52, n); idle(5);
    send_byte(8'h22, n);
    expect_ev("rd_re", EV_RE, 8'h22, 8'h00, n + 1);
    expect_ev("rd_data", EV_TX, 8'h3C, 8'h00, n + 5);
    idle(40);

    // read timeout
    rd_delay = -1;
    send_byte(8'h52, n); idle(5);
    send_byte(8'h22, n);
    expect_ev("rdto_re", EV_RE, 8'h22, 8'h00, n + 1);
    expect_ev("rdto_nak", EV_TX, 8'h15, 8'h00, n + 17);
    idle(40);

    // inter-byte timeout then a normal read
    send_byte(8'h57, n); idle(20);
    send_byte(8'h10, n); idle(100);
    rd_delay = 1;
    rd_data  = 8'h5A;
    send_byte(8'h52, n); idle(5);
    send_byte(8'h01, n);
    expect_ev("bto_re", EV_RE, 8'h01, 8'h00, n + 1);
    expect_ev("bto_data", EV_TX, 8'h5A, 8'h00, n + 3);
    idle(40);

    // unknown command, then overrun during WAIT_TX
    send_byte(8'h41, n);
    expect_ev("bad_nak", EV_TX, 8'h15, 8'h00, n + 1);
    idle(2);
    send_byte(8'h00, n);
    expect_ev("overrun", EV_OVR, 8'h00, 8'h00, n);
    idle(40);

    // transmitter busy for 20 cycles
    force_busy = 1'b1;
    send_byte(8'h57, n); idle(5);
    send_byte(8'h33, n); idle(5);
    send_byte(8'h44, n);
    expect_ev("busy_we", EV_WE, 8'h33, 8'h44, n + 1);
    expect_ev("busy_ack", EV_TX, 8'h06, 8'h00, n + 21);
    idle(20);
    force_busy = 1'b0;
    idle(40);

    // reset while in GET_DATA
    send_byte(8'h57, n); idle(5);
    send_byte(8'h10, n); idle(5);
    NRST = 1'b0;
    #1 chk_reset("mid_reset");
    idle(3);
    NRST = 1'b1;
    idle(3);
    send_byte(8'h57, n); idle(5);
    send_byte(8'h11, n); idle(5);
    send_byte(8'h01, n);
    expect_ev("rst_we", EV_WE, 8'h11, 8'h01, n + 1);
    expect_ev("rst_ack", EV_TX, 8'h06, 8'h00, n + 2);
    idle(40);

    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
